// File: rtl/shift9900_seq.sv
// Multi-cycle TMS9900 shift sequencer: one bit per SHIFT cycle through the
// external ALU, with the carry/overflow/compare status bits kept in step.
module shift9900_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [3:0]  count,
    input  logic [15:0] operand,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        st_lgt,
    output logic        st_agt,
    output logic        st_eq,
    output logic        st_c,
    output logic        st_ov,
    output logic [15:0] alu_arg1,
    output logic [15:0] alu_arg2,
    output logic [3:0]  alu_ope,
    output logic        alu_compare,
    input  logic [15:0] alu_result,
    input  logic        alu_logical_gt,
    input  logic        alu_arithmetic_gt,
    input  logic        alu_flag_zero,
    input  logic        alu_flag_carry,
    input  logic        alu_flag_overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] OP_SLA = 2'b00;

    logic [1:0]  state;
    logic [15:0] w;
    logic [1:0]  op_r;
    logic [4:0]  n;

    // ALU shift opcodes 4'hC..4'hF line up with op 00..11.
    function automatic logic [3:0] shift_ope(input logic [1:0] sel);
        return {2'b11, sel};
    endfunction

    function automatic logic [4:0] load_count(input logic [3:0] c);
        return (c == 4'd0) ? 5'd16 : {1'b0, c};
    endfunction

    assign alu_arg1    = 16'h0000;
    assign alu_compare = 1'b0;
    assign alu_arg2    = w;
    assign alu_ope     = shift_ope(op_r);

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign result = w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            w      <= 16'h0000;
            op_r   <= 2'b00;
            n      <= 5'd0;
            st_lgt <= 1'b0;
            st_agt <= 1'b0;
            st_eq  <= 1'b0;
            st_c   <= 1'b0;
            st_ov  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w     <= operand;
                        op_r  <= op;
                        n     <= load_count(count);
                        st_c  <= 1'b0;
                        st_ov <= 1'b0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    w    <= alu_result;
                    st_c <= alu_flag_carry;
                    n    <= n - 5'd1;
                    // Overflow is sticky across steps: any MSB change flags it.
                    if (op_r == OP_SLA)
                        st_ov <= st_ov | alu_flag_overflow;
                    if (n == 5'd1) begin
                        st_lgt <= alu_logical_gt;
                        st_agt <= alu_arithmetic_gt;
                        st_eq  <= alu_flag_zero;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift9900_seq.sv
// Directed bench for shift9900_seq with a one-bit-per-step 9900 shift ALU model.
module tb_shift9900_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  count;
    logic [15:0] operand;
    logic        busy, done;
    logic [15:0] result;
    logic        st_lgt, st_agt, st_eq, st_c, st_ov;
    logic [15:0] alu_arg1, alu_arg2;
    logic [3:0]  alu_ope;
    logic        alu_compare;
    logic [15:0] alu_result;
    logic        alu_logical_gt, alu_arithmetic_gt, alu_flag_zero;
    logic        alu_flag_carry, alu_flag_overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift9900_seq dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .op                (op),
        .count             (count),
        .operand           (operand),
        .busy              (busy),
        .done              (done),
        .result            (result),
        .st_lgt            (st_lgt),
        .st_agt            (st_agt),
        .st_eq             (st_eq),
        .st_c              (st_c),
        .st_ov             (st_ov),
        .alu_arg1          (alu_arg1),
        .alu_arg2          (alu_arg2),
        .alu_ope           (alu_ope),
        .alu_compare       (alu_compare),
        .alu_result        (alu_result),
        .alu_logical_gt    (alu_logical_gt),
        .alu_arithmetic_gt (alu_arithmetic_gt),
        .alu_flag_zero     (alu_flag_zero),
        .alu_flag_carry    (alu_flag_carry),
        .alu_flag_overflow (alu_flag_overflow)
    );

    // Single-bit shift ALU: C=SLA, D=SRA, E=SRC, F=SRL.
    always_comb begin
        alu_result        = alu_arg2;
        alu_flag_carry    = 1'b0;
        alu_flag_overflow = 1'b0;
        case (alu_ope)
            4'hC: begin
                alu_result        = {alu_arg2[14:0], 1'b0};
                alu_flag_carry    = alu_arg2[15];
                alu_flag_overflow = alu_arg2[15] ^ alu_arg2[14];
            end
            4'hD: begin
                alu_result     = {alu_arg2[15], alu_arg2[15:1]};
                alu_flag_carry = alu_arg2[0];
            end
            4'hE: begin
                alu_result     = {alu_arg2[0], alu_arg2[15:1]};
                alu_flag_carry = alu_arg2[0];
            end
            4'hF: begin
                alu_result     = {1'b0, alu_arg2[15:1]};
                alu_flag_carry = alu_arg2[0];
            end
            default: ;
        endcase
        alu_logical_gt    = (alu_result != 16'h0000);
        alu_arithmetic_gt = ($signed(alu_result) > 16'sd0);
        alu_flag_zero     = (alu_result == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [4:0] status();
        return {st_lgt, st_agt, st_eq, st_c, st_ov};
    endfunction

    // exp_st = {lgt, agt, eq, c, ov}
    task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] c,
                          input logic [15:0] x, input int exp_cyc,
                          input logic [15:0] exp_res, input logic [4:0] exp_st);
        int cyc;
        op = o; count = c; operand = x; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        operand = 16'hDEAD;
        cyc = 1;
        check({tag, "_ope"}, 32'(alu_ope), 32'({2'b11, o}));
        check({tag, "_arg2"}, 32'(alu_arg2), 32'(x));
        check({tag, "_clr_c_ov"}, 32'({st_c, st_ov}), 32'd0);
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_status"}, 32'(status()), 32'(exp_st));
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'({busy, done}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hold"}, 32'({result, 11'd0, status()}), 32'({exp_res, 11'd0, exp_st}));
    endtask

    initial begin
        int ndone;
        int cyc;
        reset = 1'b1; start = 1'b1; op = 2'b11; count = 4'd3; operand = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'({busy, done, result, status()}), 32'd0);
        check("reset_alu", 32'({alu_arg2, alu_ope}), 32'({16'h0000, 4'hC}));
        check("reset_alu_const", 32'({alu_arg1, alu_compare}), 32'd0);
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("idle_hold", 32'({busy, result}), 32'd0);

        run_op("sla_4000_1",  2'b00, 4'd1,  16'h4000, 2,  16'h8000, 5'b10001);
        run_op("sra_8001_1",  2'b01, 4'd1,  16'h8001, 2,  16'hC000, 5'b10010);
        run_op("src_1234_16", 2'b10, 4'd0,  16'h1234, 17, 16'h1234, 5'b11000);
        run_op("srl_ffff_15", 2'b11, 4'd15, 16'hFFFF, 16, 16'h0001, 5'b11010);
        run_op("sla_0001_16", 2'b00, 4'd0,  16'h0001, 17, 16'h0000, 5'b00111);
        run_op("sra_8000_4",  2'b01, 4'd4,  16'h8000, 5,  16'hF800, 5'b10000);
        run_op("sla_0003_1",  2'b00, 4'd1,  16'h0003, 2,  16'h0006, 5'b11000);

        // Reset mid-SHIFT: start SRL count 8, reset asserted in cycle 4.
        op = 2'b11; count = 4'd8; operand = 16'hFF00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_outs", 32'({busy, done, result, status()}), 32'd0);
        check("midrst_alu", 32'({alu_arg2, alu_ope}), 32'({16'h0000, 4'hC}));
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run_op("srl_ff00_8", 2'b11, 4'd8, 16'hFF00, 9, 16'h00FF, 5'b11000);

        // start held high throughout the operation: only one executes.
        op = 2'b11; count = 4'd2; operand = 16'h0004; start = 1'b1;
        @(posedge clk); #1;
        operand = 16'hFFFF; op = 2'b00; count = 4'd5;
        ndone = 0;
        cyc = 1;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                ndone++;
                check("held_latency", 32'(cyc), 32'd3);
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("held_one_done", 32'(ndone), 32'd1);
        check("held_result", 32'({busy, result}), 32'({1'b0, 16'h0001}));
        check("held_status", 32'(status()), 32'(5'b11000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
